// File: rtl/apu_mixer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apu_mixer_pkg
//  Description : Shared widths, state encoding, source-index type and the
//                DAC-code-to-signed-value helper for the APU output mixer.
//                Build macro APU_MIXER_VIN_EN adds VIN as a fifth source.
//  Revision    : 1.0 - initial release
// ============================================================================
package apu_mixer_pkg;

    localparam int SUM_W       = 8;   // per-side accumulator, |sum| <= 75
    localparam int OUT_W       = 11;  // scaled product, |product| <= 600
    localparam int VAL_W       = 6;   // one source value, -15..+15
    localparam int SCALE_STEPS = 3;   // one shift-add per volume bit
    localparam int MAX_SRC     = 5;   // storage is always sized for VIN

`ifdef APU_MIXER_VIN_EN
    localparam int NSRC = 5;
`else
    localparam int NSRC = 4;
`endif

    typedef logic [2:0] src_idx_t;

    localparam src_idx_t LAST_SRC  = src_idx_t'(NSRC - 1);
    localparam src_idx_t LAST_STEP = src_idx_t'(SCALE_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // DAC code c (0..15) becomes the signed offset 2c-15.
    function automatic logic signed [VAL_W-1:0] src_value(input logic [3:0] code);
        return $signed({1'b0, code, 1'b0}) - 6'sd15;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apu_mixer_if.sv
`default_nettype none
// ============================================================================
//  Module      : apu_mixer_if
//  Description : Sample/control bundle between the channel generators, the
//                APU control block (NR50/NR51) and the mixer.
//                master : producer side (drives codes, masks, volumes, tick)
//                slave  : mixer side (drives l_out/r_out/out_valid/busy/overrun)
//  Revision    : 1.0 - initial release
// ============================================================================
interface apu_mixer_if;
    import apu_mixer_pkg::*;

    logic                    sample_tick;
    logic [3:0]              ch1_out, ch2_out, ch3_out, ch4_out;
    logic                    nch1_active, nch2_active, nch3_active, nch4_active;
    logic [3:0]              rmixer, lmixer;
    logic [2:0]              nrvolume, nlvolume;
    logic                    vin_r_ena, vin_l_ena;
    logic [3:0]              vin;
    logic signed [OUT_W-1:0] l_out, r_out;
    logic                    out_valid;
    logic                    busy;
    logic                    overrun;

    modport master (
        output sample_tick,
        output ch1_out, ch2_out, ch3_out, ch4_out,
        output nch1_active, nch2_active, nch3_active, nch4_active,
        output rmixer, lmixer, nrvolume, nlvolume,
        output vin_r_ena, vin_l_ena, vin,
        input  l_out, r_out, out_valid, busy, overrun
    );

    modport slave (
        input  sample_tick,
        input  ch1_out, ch2_out, ch3_out, ch4_out,
        input  nch1_active, nch2_active, nch3_active, nch4_active,
        input  rmixer, lmixer, nrvolume, nlvolume,
        input  vin_r_ena, vin_l_ena, vin,
        output l_out, r_out, out_valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/apu_mixer_side.sv
`default_nettype none
// ============================================================================
//  Module      : apu_mixer_side
//  Description : One output side of the mixer: signed accumulator followed by
//                a serial shift-add scaler computing sum * (vol + 1).
//  Ports       : apuv_4mhz, napu_reset (sync, active-low)
//                i_clear    - zero accumulator and product (new mix)
//                i_acc_en   - ACC step: add i_src_val when i_route is set
//                i_scale_en - SCALE step i_step (0..2) using i_vol bit
//                o_prod     - current product (final after last SCALE step)
//  Revision    : 1.0 - initial release
// ============================================================================
module apu_mixer_side
    import apu_mixer_pkg::*;
(
    input  wire logic                    apuv_4mhz,
    input  wire logic                    napu_reset,
    input  wire logic                    i_clear,
    input  wire logic                    i_acc_en,
    input  wire logic                    i_route,
    input  wire logic signed [VAL_W-1:0] i_src_val,
    input  wire logic                    i_scale_en,
    input  wire logic [1:0]              i_step,
    input  wire logic [2:0]              i_vol,
    output logic signed [OUT_W-1:0]      o_prod
);

    logic signed [SUM_W-1:0] r_sum;
    logic signed [OUT_W-1:0] r_prod;
    logic signed [OUT_W-1:0] w_sum_ext;
    logic signed [OUT_W-1:0] w_base;
    logic signed [OUT_W-1:0] w_addend;

    assign w_sum_ext = {{(OUT_W-SUM_W){r_sum[SUM_W-1]}}, r_sum};

    // Step 0 starts from the sum itself (the "+1" in vol+1); later steps
    // build on the running product.
    assign w_base = (i_step == 2'd0) ? w_sum_ext : r_prod;

    always_comb begin
        w_addend = '0;
        case (i_step)
            2'd0:    if (i_vol[0]) w_addend = w_sum_ext;
            2'd1:    if (i_vol[1]) w_addend = w_sum_ext <<< 1;
            2'd2:    if (i_vol[2]) w_addend = w_sum_ext <<< 2;
            default: w_addend = '0;
        endcase
    end

    always_ff @(posedge apuv_4mhz) begin
        if (!napu_reset) begin
            r_sum  <= '0;
            r_prod <= '0;
        end else if (i_clear) begin
            r_sum  <= '0;
            r_prod <= '0;
        end else if (i_acc_en) begin
            if (i_route) begin
                r_sum <= r_sum + {{(SUM_W-VAL_W){i_src_val[VAL_W-1]}}, i_src_val};
            end
        end else if (i_scale_en) begin
            r_prod <= w_base + w_addend;
        end
    end

    assign o_prod = r_prod;

endmodule
`default_nettype wire

// File: rtl/apu_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : apu_mixer
//  Description : NR50/NR51 stereo mixer. Snapshots channel codes, routing and
//                volumes on sample_tick, accumulates one source per clock,
//                scales each side by (vol+1) and presents a registered signed
//                sample pair with a one-cycle out_valid pulse.
//                Build macro APU_MIXER_VIN_EN adds VIN as a fifth source.
//  Ports       : apuv_4mhz  - clock
//                napu_reset - synchronous, active-low reset
//                bus        - apu_mixer_if.slave (inputs, l_out/r_out,
//                             out_valid, busy, overrun)
//  Revision    : 1.0 - initial release
// ============================================================================
module apu_mixer
    import apu_mixer_pkg::*;
(
    input wire logic   apuv_4mhz,
    input wire logic   napu_reset,
    apu_mixer_if.slave bus
);

    state_t                  r_state;
    state_t                  w_next_state;
    src_idx_t                r_cnt;

    logic [3:0]              r_code [MAX_SRC];
    logic [MAX_SRC-1:0]      r_lroute;
    logic [MAX_SRC-1:0]      r_rroute;
    logic [2:0]              r_lvol;
    logic [2:0]              r_rvol;

    logic signed [OUT_W-1:0] r_l_out;
    logic signed [OUT_W-1:0] r_r_out;
    logic                    r_out_valid;
    logic                    r_overrun;

    logic                    w_accept;
    logic                    w_acc_en;
    logic                    w_scale_en;
    logic                    w_done;
    logic [3:0]              w_nact;
    logic signed [VAL_W-1:0] w_src_val;
    logic signed [OUT_W-1:0] w_lprod;
    logic signed [OUT_W-1:0] w_rprod;

    // The FSM is back in IDLE during the out_valid cycle; a tick there still
    // belongs to the mix being delivered, so it is dropped and reported.
    assign w_accept = bus.sample_tick && (r_state == IDLE) && !r_out_valid;

    assign w_nact = {bus.nch4_active, bus.nch3_active, bus.nch2_active, bus.nch1_active};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge apuv_4mhz) begin
        if (!napu_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)            w_next_state = ACC;
            ACC:     if (r_cnt == LAST_SRC)   w_next_state = SCALE;
            SCALE:   if (r_cnt == LAST_STEP)  w_next_state = DONE;
            DONE:                             w_next_state = IDLE;
            default:                          w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_acc_en   = 1'b0;
        w_scale_en = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ACC:     w_acc_en   = 1'b1;
            SCALE:   w_scale_en = 1'b1;
            DONE:    w_done     = 1'b1;
            default: ;
        endcase
    end

    // Source index in ACC, volume-bit index in SCALE; zero otherwise.
    always_ff @(posedge apuv_4mhz) begin
        if (!napu_reset) begin
            r_cnt <= '0;
        end else if ((w_acc_en && r_cnt != LAST_SRC) ||
                     (w_scale_en && r_cnt != LAST_STEP)) begin
            r_cnt <= r_cnt + src_idx_t'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // ----------------------------------------------------------- snapshot
    // Channel enable is folded into the route bits at capture time.
    always_ff @(posedge apuv_4mhz) begin
        if (!napu_reset) begin
            for (int i = 0; i < MAX_SRC; i++) begin
                r_code[i] <= '0;
            end
            r_lroute <= '0;
            r_rroute <= '0;
            r_lvol   <= '0;
            r_rvol   <= '0;
        end else if (w_accept) begin
            r_code[0]     <= bus.ch1_out;
            r_code[1]     <= bus.ch2_out;
            r_code[2]     <= bus.ch3_out;
            r_code[3]     <= bus.ch4_out;
            r_lroute[3:0] <= bus.lmixer & ~w_nact;
            r_rroute[3:0] <= bus.rmixer & ~w_nact;
            r_lvol        <= ~bus.nlvolume;
            r_rvol        <= ~bus.nrvolume;
`ifdef APU_MIXER_VIN_EN
            r_code[4]     <= bus.vin;
            r_lroute[4]   <= bus.vin_l_ena;
            r_rroute[4]   <= bus.vin_r_ena;
`else
            r_code[4]     <= '0;
            r_lroute[4]   <= 1'b0;
            r_rroute[4]   <= 1'b0;
`endif
        end
    end

    assign w_src_val = src_value(r_code[r_cnt]);

    // ----------------------------------------------------------- datapath
    apu_mixer_side u_left (
        .apuv_4mhz  (apuv_4mhz),
        .napu_reset (napu_reset),
        .i_clear    (w_accept),
        .i_acc_en   (w_acc_en),
        .i_route    (r_lroute[r_cnt]),
        .i_src_val  (w_src_val),
        .i_scale_en (w_scale_en),
        .i_step     (r_cnt[1:0]),
        .i_vol      (r_lvol),
        .o_prod     (w_lprod)
    );

    apu_mixer_side u_right (
        .apuv_4mhz  (apuv_4mhz),
        .napu_reset (napu_reset),
        .i_clear    (w_accept),
        .i_acc_en   (w_acc_en),
        .i_route    (r_rroute[r_cnt]),
        .i_src_val  (w_src_val),
        .i_scale_en (w_scale_en),
        .i_step     (r_cnt[1:0]),
        .i_vol      (r_rvol),
        .o_prod     (w_rprod)
    );

    // ------------------------------------------------------------ outputs
    always_ff @(posedge apuv_4mhz) begin
        if (!napu_reset) begin
            r_l_out     <= '0;
            r_r_out     <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= w_done;
            r_overrun   <= bus.sample_tick && !w_accept;
            if (w_done) begin
                r_l_out <= w_lprod;
                r_r_out <= w_rprod;
            end
        end
    end

    assign bus.l_out     = r_l_out;
    assign bus.r_out     = r_r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = (r_state != IDLE) || r_out_valid;

endmodule
`default_nettype wire
